// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: ALU control decode plus multiply/divide busy sequencing with HI/LO hazard stalls
module alu_op_sequencer #(
  parameter int FUNCT_LENGTH   = 6,
  parameter int ALU_OP_LENGTH  = 4,
  parameter int CONTROL_LENGTH = 4,
  parameter int MULT_CYCLES    = 4,
  parameter int DIV_CYCLES     = 32,
  parameter int CNT_WIDTH      = 6
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic                      issue_valid,
  input  logic [ALU_OP_LENGTH-1:0]  alu_op,
  input  logic [FUNCT_LENGTH-1:0]   func,
  input  logic                      flush,
  output logic [CONTROL_LENGTH-1:0] control,
  output logic                      md_unsigned,
  output logic                      issue_ready,
  output logic                      stall,
  output logic                      md_start,
  output logic                      busy,
  output logic                      hilo_we
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] WB   = 2'd2;
  logic [1:0] state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [3:0] code;
  logic r_type, is_md, is_hl, is_mult;
  assign r_type  = alu_op == '0;
  assign is_md   = r_type && (int'(func) inside {'b011000, 'b011001, 'b011010, 'b011011});
  assign is_hl   = r_type && (int'(func) inside {'b010000, 'b010001, 'b010010, 'b010011});
  assign is_mult = int'(func) inside {'b011000, 'b011001};
  assign md_unsigned = r_type && (int'(func) inside {'b011001, 'b011011});
  // Map the operation class / R-type func field onto the ALU control code
  always_comb begin
    code = 4'd0;
    if (r_type)
      case (int'(func))
        'b100000: code = 4'd0;
        'b100010: code = 4'd1;
        'b100001: code = 4'd2;
        'b100011: code = 4'd3;
        'b100100: code = 4'd4;
        'b100110: code = 4'd5;
        'b100111: code = 4'd6;
        'b000000, 'b000100: code = 4'd7;
        'b000010: code = 4'd8;
        'b101010: code = 4'd9;
        'b011000, 'b011001: code = 4'd10;
        'b011010, 'b011011: code = 4'd11;
        'b000110, 'b000011: code = 4'd12;
        'b100101: code = 4'd13;
        default:  code = 4'd0;
      endcase
    else
      case (int'(alu_op))
        1:       code = 4'd0;
        2:       code = 4'd2;
        3:       code = 4'd4;
        4:       code = 4'd5;
        5:       code = 4'd13;
        6:       code = 4'd9;
        7:       code = 4'd14;
        8:       code = 4'd3;
        default: code = 4'd0;
      endcase
  end
  assign control = CONTROL_LENGTH'(code);
  // Only HI/LO producers and consumers wait on the multiply/divide unit; reset forces the idle view
  assign issue_ready = !flush && (!rst_b || !((is_md || is_hl) && state != IDLE));
  assign stall       = issue_valid && !issue_ready;
  assign md_start    = rst_b && issue_valid && issue_ready && is_md;
  assign busy        = state != IDLE;
  // Next-state and countdown: flush aborts, BUSY counts the op latency down to the WB write cycle
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (state == IDLE && md_start) begin
      state_nxt = BUSY;
      cnt_nxt   = is_mult ? CNT_WIDTH'(MULT_CYCLES) : CNT_WIDTH'(DIV_CYCLES);
    end else if (state == BUSY) begin
      state_nxt = cnt == CNT_WIDTH'(1) ? WB : BUSY;
      cnt_nxt   = cnt - CNT_WIDTH'(1);
    end else if (state == WB) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end
  // State registers; hilo_we is registered so it is high exactly during WB
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state   <= IDLE;
      cnt     <= '0;
      hilo_we <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      hilo_we <= state_nxt == WB;
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: decode tables, directed multi-cycle sequences and a random run against a cycle-number model
module tb_alu_op_sequencer;
  localparam int MC = 4;
  localparam int DC = 32;
  logic clk = 1'b0, clk_en = 1'b1;
  logic rst_b, issue_valid, flush;
  logic [3:0] alu_op;
  logic [5:0] func;
  logic [3:0] control;
  logic md_unsigned, issue_ready, stall, md_start, busy, hilo_we;
  int total = 0, passed = 0;
  int cyc = 0, st = 0, lat = 0;
  bit act = 0;

  alu_op_sequencer #(.FUNCT_LENGTH(6), .ALU_OP_LENGTH(4), .CONTROL_LENGTH(4),
                     .MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_WIDTH(6)) dut (
    .clk(clk), .rst_b(rst_b), .issue_valid(issue_valid), .alu_op(alu_op), .func(func),
    .flush(flush), .control(control), .md_unsigned(md_unsigned), .issue_ready(issue_ready),
    .stall(stall), .md_start(md_start), .busy(busy), .hilo_we(hilo_we));

  always #5 clk = clk_en ? ~clk : clk;

  typedef struct { logic [3:0] op; logic [5:0] fn; logic [3:0] ctl; logic mdu; } vec_t;
  vec_t vt[14];

  int op_ctl[16] = '{0, 0, 2, 4, 5, 13, 9, 14, 3, 0, 0, 0, 0, 0, 0, 0};
  int rf_fn[19]  = '{32, 34, 33, 35, 36, 38, 39, 0, 4, 2, 42, 24, 25, 26, 27, 6, 3, 37, 1};
  int rf_ctl[19] = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 8, 9, 10, 10, 11, 11, 12, 12, 13, 0};

  function automatic int ref_ctl(int op, int fn);
    if (op != 0) return op_ctl[op];
    foreach (rf_fn[i]) if (rf_fn[i] == fn) return rf_ctl[i];
    return 0;
  endfunction
  function automatic bit ref_md(int op, int fn);
    return op == 0 && fn >= 24 && fn <= 27;
  endfunction
  function automatic bit ref_hl(int op, int fn);
    return op == 0 && fn >= 16 && fn <= 19;
  endfunction
  function automatic bit m_busy();
    return act && cyc > st && cyc <= st + lat + 1;
  endfunction
  function automatic bit m_we();
    return act && cyc == st + lat + 1;
  endfunction

  task automatic chk(string name, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, a, e);
    else passed++;
  endtask

  task automatic drive(bit v, int op, int fn, bit fl);
    issue_valid = v;
    alu_op = 4'(op);
    func = 6'(fn);
    flush = fl;
  endtask

  task automatic step();
    bit e_rdy, acc;
    @(negedge clk);
    e_rdy = flush ? 1'b0 : !rst_b ? 1'b1 : !((ref_md(alu_op, func) || ref_hl(alu_op, func)) && m_busy());
    acc = rst_b && issue_valid && e_rdy && ref_md(alu_op, func);
    chk("m_control", 32'(control), 32'(ref_ctl(alu_op, func)));
    chk("m_md_unsigned", 32'(md_unsigned), 32'(alu_op == 0 && (func == 25 || func == 27)));
    chk("m_issue_ready", 32'(issue_ready), 32'(e_rdy));
    chk("m_stall", 32'(stall), 32'(issue_valid && !e_rdy));
    chk("m_md_start", 32'(md_start), 32'(acc));
    chk("m_busy", 32'(busy), 32'(m_busy()));
    chk("m_hilo_we", 32'(hilo_we), 32'(m_we()));
    @(posedge clk);
    if (!rst_b || flush) act = 0;
    else if (acc) begin
      act = 1;
      st = cyc;
      lat = (func == 24 || func == 25) ? MC : DC;
    end
    cyc++;
    #1;
  endtask

  initial begin
    vt[0]  = '{4'd0, 6'b100000, 4'd0, 1'b0};
    vt[1]  = '{4'd0, 6'b100010, 4'd1, 1'b0};
    vt[2]  = '{4'd0, 6'b100001, 4'd2, 1'b0};
    vt[3]  = '{4'd0, 6'b100111, 4'd6, 1'b0};
    vt[4]  = '{4'd0, 6'b000100, 4'd7, 1'b0};
    vt[5]  = '{4'd0, 6'b101010, 4'd9, 1'b0};
    vt[6]  = '{4'd0, 6'b011001, 4'd10, 1'b1};
    vt[7]  = '{4'd0, 6'b011011, 4'd11, 1'b1};
    vt[8]  = '{4'd0, 6'b011010, 4'd11, 1'b0};
    vt[9]  = '{4'd0, 6'b000011, 4'd12, 1'b0};
    vt[10] = '{4'd0, 6'b100101, 4'd13, 1'b0};
    vt[11] = '{4'd7, 6'b011001, 4'd14, 1'b0};
    vt[12] = '{4'd8, 6'b000000, 4'd3, 1'b0};
    vt[13] = '{4'd9, 6'b100001, 4'd0, 1'b0};
    rst_b = 1'b0;
    drive(1, 0, 24, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_hilo_we", 32'(hilo_we), 0);
    chk("rst_md_start", 32'(md_start), 0);
    chk("rst_ready", 32'(issue_ready), 1);
    flush = 1'b1;
    #1;
    chk("rst_ready_flush", 32'(issue_ready), 0);
    rst_b = 1'b1;
    drive(0, 0, 0, 0);
    step();
    // Combinational decode with the clock parked in IDLE
    clk_en = 1'b0;
    #20;
    foreach (vt[i]) begin
      drive(1, vt[i].op, vt[i].fn, 0);
      #1;
      chk("tbl_control", 32'(control), 32'(vt[i].ctl));
      chk("tbl_md_unsigned", 32'(md_unsigned), 32'(vt[i].mdu));
    end
    for (int op = 0; op < 16; op++)
      for (int fn = 0; fn < 64; fn++) begin
        drive(1, op, fn, 0);
        #1;
        chk("sweep_control", 32'(control), 32'(ref_ctl(op, fn)));
        chk("sweep_md_unsigned", 32'(md_unsigned), 32'(op == 0 && (fn == 25 || fn == 27)));
        chk("sweep_stall", 32'(stall), 0);
      end
    drive(0, 0, 0, 0);
    clk_en = 1'b1;
    step();
    // Multiply timeline
    drive(1, 0, 24, 0);
    #1 chk("mult_md_start", 32'(md_start), 1);
    step();
    drive(0, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      #1;
      chk("mult_busy", 32'(busy), 32'(k <= 5));
      chk("mult_hilo_we", 32'(hilo_we), 32'(k == 5));
      step();
    end
    // divu followed by a stalled mfhi
    drive(1, 0, 27, 0);
    #1 chk("divu_md_unsigned", 32'(md_unsigned), 1);
    chk("divu_md_start", 32'(md_start), 1);
    step();
    drive(1, 0, 16, 0);
    for (int k = 1; k <= 34; k++) begin
      #1 chk("mfhi_stall", 32'(stall), 32'(k <= 33));
      step();
    end
    // Independent op overlaps BUSY, second mult waits for IDLE
    drive(1, 0, 24, 0);
    step();
    drive(1, 0, 33, 0);
    #1 chk("overlap_ready", 32'(issue_ready), 1);
    chk("overlap_control", 32'(control), 2);
    step();
    drive(1, 0, 24, 0);
    for (int k = 2; k <= 6; k++) begin
      #1 chk("mult2_stall", 32'(stall), 32'(k <= 5));
      chk("mult2_md_start", 32'(md_start), 32'(k == 6));
      step();
    end
    drive(0, 0, 0, 0);
    repeat (6) step();
    // Flush mid-multiply and flush against a same-cycle issue
    drive(1, 0, 24, 0);
    step();
    drive(0, 0, 0, 0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int k = 3; k <= 7; k++) begin
      #1 chk("flush_busy", 32'(busy), 0);
      chk("flush_hilo_we", 32'(hilo_we), 0);
      step();
    end
    drive(1, 0, 24, 1);
    #1 chk("flush_issue_md_start", 32'(md_start), 0);
    chk("flush_issue_ready", 32'(issue_ready), 0);
    step();
    drive(0, 0, 0, 0);
    #1 chk("flush_issue_busy", 32'(busy), 0);
    step();
    // Reset mid-divide
    drive(1, 0, 26, 0);
    step();
    drive(0, 0, 0, 0);
    repeat (2) step();
    rst_b = 1'b0;
    step();
    rst_b = 1'b1;
    #1 chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_hilo_we", 32'(hilo_we), 0);
    drive(1, 0, 24, 0);
    #1 chk("rstmid_md_start", 32'(md_start), 1);
    step();
    drive(0, 0, 0, 0);
    #1 chk("rstmid_busy_after", 32'(busy), 1);
    repeat (6) step();
    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int pick;
      pick = $urandom_range(0, 9);
      drive($urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 0,
            pick < 4 ? $urandom_range(24, 27) : pick < 7 ? $urandom_range(16, 19) : $urandom_range(0, 63),
            $urandom_range(0, 29) == 0);
      rst_b = $urandom_range(0, 199) != 0;
      step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  FUNCT_LENGTH  6   R-type func field width
  ALU_OP_LENGTH  4   alu_op width
  CONTROL_LENGTH  4   ALU control code width
  MULT_CYCLES  4   multiply latency in BUSY cycles, 1 or more
  DIV_CYCLES  32   divide latency in BUSY cycles, 1 or more
  CNT_WIDTH  6   countdown width; must hold max(MULT_CYCLES, DIV_CYCLES)
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  single clock, rising edge
  rst_b  in  1  synchronous active-low reset
  issue_valid  in  1  decoded instruction presented
  alu_op  in  ALU_OP_LENGTH  ALU operation class; 0 means R-type
  func  in  FUNCT_LENGTH  R-type func field
  flush  in  1  abort the in-flight multiply/divide
  control  out  CONTROL_LENGTH  ALU control code
  md_unsigned  out  1  multu/divu decoded
  issue_ready  out  1  instruction accepted this cycle
  stall  out  1  issue_valid and not issue_ready
  md_start  out  1  multiply/divide accepted this cycle
  busy  out  1  state is not IDLE
  hilo_we  out  1  HI/LO write strobe

Function
REQ-003 control SHALL be combinational from alu_op/func every cycle, independent of state and issue_valid.
REQ-004 alu_op=0 func map: 100000→0, 100010→1, 100001→2, 100011→3, 100100→4, 100110→5, 100111→6, 000000→7, 000100→7, 000010→8, 101010→9, 011000→10, 011001→10, 011010→11, 011011→11, 000110→12, 000011→12, 100101→13, others→0.
REQ-005 alu_op≠0 map: 1→0, 2→2, 3→4, 4→5, 5→13, 6→9, 7→14, 8→3, others→0.
REQ-006 md_unsigned=1 only for alu_op=0 with func 011001 or 011011; else 0.
REQ-007 Classes (alu_op=0 only): MD = func 011000/011001/011010/011011; HL = func 010000/010001/010010/010011 (mfhi, mthi, mflo, mtlo); every other encoding is plain.
REQ-008 States: IDLE, BUSY, WB.
REQ-009 Accept = issue_valid and issue_ready.
REQ-010 issue_ready=0 if flush=1.
REQ-011 Otherwise issue_ready=0 for an MD or HL op in BUSY or WB.
REQ-012 Otherwise issue_ready=1; plain ops are always ready absent flush.
REQ-013 md_start SHALL equal accept of an MD op; combinational, so it is high in the accept cycle.
REQ-014 On an MD accept in IDLE: next state BUSY; counter loads MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu).
REQ-015 In BUSY the counter SHALL decrement each cycle; when the counter is 1, next state is WB and the counter becomes 0.
REQ-016 Hence BUSY SHALL last exactly MULT_CYCLES or DIV_CYCLES cycles.
REQ-017 WB SHALL last one cycle with hilo_we=1 (registered), then go to IDLE.
REQ-018 hilo_we SHALL be 0 in every state other than WB.
REQ-019 An HL op arriving in WB SHALL stall; it is accepted in the following IDLE cycle, after HI/LO is written.
REQ-020 flush=1 in any state: next state IDLE, counter 0, no hilo_we pulse; flush has priority over a same-cycle issue.
REQ-021 flush in WB: hilo_we stays 1 that cycle (write already committed), then IDLE.
REQ-022 busy = (state≠IDLE).
REQ-023 stall = issue_valid and not issue_ready.

Reset
REQ-024 rst_b=0 at a clock edge SHALL force state IDLE, counter 0, hilo_we 0; this overrides flush and issue.
REQ-025 With rst_b=0 held, outputs are busy=0, md_start=0, and issue_ready=1 unless flush is high.
REQ-026 control and md_unsigned follow the inputs during reset.
REQ-027 Reset mid-BUSY SHALL abandon the operation with no hilo_we pulse.

Verification
REQ-028 Decode sweep: every alu_op 0..15 and func 0..63 → control and md_unsigned match REQ-004..006; no stalls in IDLE.
REQ-029 MULT_CYCLES=4: accept func 011000 at cycle 0 → md_start=1 at cycle 0; busy at cycles 1-5; BUSY at 1-4; hilo_we=1 only at cycle 5; IDLE at cycle 6.
REQ-030 Hazard: divu at cycle 0 (DIV_CYCLES=32), mfhi held valid from cycle 1 → stall=1 at cycles 1-33; accepted at cycle 34; md_unsigned=1 at cycle 0.
REQ-031 Overlap: during BUSY, issue addu (alu_op 0, func 100001) → issue_ready=1, control=2; a second mult in BUSY → stall until the IDLE cycle.
REQ-032 flush at cycle 2 of a mult → IDLE at cycle 3, hilo_we never pulses; mult+flush in the same IDLE cycle → not accepted, md_start=0.
REQ-033 rst_b=0 at cycle 3 of a div → IDLE, busy=0, hilo_we=0 next cycle; a new mult is accepted immediately after release.
